activation_execution: RTL and testbench
=======================================

Name: activation_execution

Overview:
Tile-streaming activation engine; successor to the single-function ReLU executor. It reads a vector tile-by-tile from a source buffer through the buffer controller and applies a runtime-selected activation: pass-through, ReLU, clamped ReLU, or leaky ReLU. Each result tile is written to a destination buffer. It sits beside the other execution units under the top-level instruction decoder and shares the same buffer-controller read/write tile interface.

Parameters:
DATA_WIDTH, 8, signed element width
TILE_ELEMS, 32, elements per tile
LEN_WIDTH, 10, width of the vector length field
BUF_ID_WIDTH, 5, buffer identifier width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle start pulse; sampled only in IDLE
mode  in  2  0=PASS, 1=RELU, 2=CLAMP, 3=LEAKY
clamp_max  in  DATA_WIDTH  signed upper bound for CLAMP
leak_shift  in  3  arithmetic right-shift applied to negatives in LEAKY
x_buffer_id  in  BUF_ID_WIDTH  source buffer
dest_buffer_id  in  BUF_ID_WIDTH  destination buffer
length  in  LEN_WIDTH  element count
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle completion pulse
vec_read_enable  out  1  one-cycle tile read request
vec_read_buffer_id  out  BUF_ID_WIDTH  latched x_buffer_id
vec_read_tile  in  TILE_ELEMS x DATA_WIDTH  signed read data
vec_read_valid  in  1  read data valid, one cycle
vec_write_enable  out  1  one-cycle tile write strobe
vec_write_buffer_id  out  BUF_ID_WIDTH  latched dest_buffer_id
vec_write_tile  out  TILE_ELEMS x DATA_WIDTH  registered result tile
zero_count  out  LEN_WIDTH+1  count of zero outputs (optional feature)

Behaviour:
- Reset value 0 for every output: busy, done, enables, buffer ids, vec_write_tile, zero_count. FSM returns to IDLE.
- Reset mid-operation: abort immediately. No done pulse and no further reads or writes.
- FSM states: IDLE, WAIT_TILE, COMPLETE.
- IDLE + start with length>0:
  - Latch mode, clamp_max, leak_shift, length and both buffer ids.
  - tiles_total = ceil(length/TILE_ELEMS); clear the tile counter and element offset.
  - Next cycle: vec_read_enable=1, busy=1, state WAIT_TILE.
- IDLE + start with length==0: go to COMPLETE with busy=1. done pulses on the following cycle. No read or write is issued.
- WAIT_TILE: vec_read_valid at a rising edge captures the activation of vec_read_tile. The next cycle has vec_write_enable=1 and vec_write_tile valid.
  - Lane i with offset+i >= length is written as 0.
  - If more tiles remain, vec_read_enable=1 in the same cycle as the write.
  - Otherwise go to COMPLETE.
- COMPLETE: done=1 for one cycle, busy falls in the same cycle, next state IDLE.
- Latency for N tiles with read latency L cycles (request to valid): done = 1 + N*(L+1) + 1 cycles after the start edge.
- vec_read_valid outside WAIT_TILE is ignored. start outside IDLE is ignored; latched config is unaffected.
- Read and write enables are never high for more than one consecutive cycle per tile.
- Arithmetic, per element x:
  - PASS: y=x.
  - RELU: y = x<0 ? 0 : x.
  - CLAMP: y = min(max(x,0), clamp_max). If clamp_max<0, y=0.
  - LEAKY: y = x<0 ? x>>>leak_shift : x. Arithmetic shift rounds toward -inf, so -1>>>k stays -1.
  - No overflow is possible; result width equals DATA_WIDTH.
- mode, clamp_max and leak_shift changes during busy have no effect.

Optional Feature:
ACT_ZERO_COUNT_EN
- Defined: zero_count clears at accepted start. It adds the number of in-length lanes with y==0 on each write cycle. It holds its final value from done until the next start.
- Undefined: the zero_count port still exists, is tied to 0, and no counter logic is built.

Test Plan:
- RELU, length=40, L=1, tile0 lanes 0..31 = -16..15, tile1 all -3:
  - Expect 2 reads and 2 writes.
  - Write0 = 0 for lanes 0..16, then 1..15.
  - Write1 = all 0, including padded lanes 8..31.
  - done at cycle 6; zero_count=25 (macro on).
- CLAMP clamp_max=6 on {-5,3,6,7,127}:
  - Expect {0,3,6,6,6}.
  - clamp_max=-1 gives all 0.
- LEAKY shift=2 on {-7,-1,-128,5}:
  - Expect {-2,-1,-32,5}.
  - PASS returns the input unchanged.
- length=0:
  - No vec_read_enable or vec_write_enable.
  - busy high 2 cycles; done 2 cycles after start.
- Read latency L=4, length=64, with a start pulse and a stray valid injected mid-run:
  - Both are ignored; exactly 2 writes occur.
  - Buffer ids match values latched at the original start.
- rst asserted while in WAIT_TILE on tile 1 of 3:
  - All outputs 0 in the same cycle and no done.
  - A fresh start afterwards completes normally.

Source files
------------

// File: rtl/activation_execution.sv
`default_nettype none
// =============================================================================
// Module   : activation_execution
// Brief    : Tile-streaming activation engine (PASS / RELU / CLAMP / LEAKY).
//            Define ACT_ZERO_COUNT_EN to build the zero-output counter.
// Revision : 1.0 - initial release
// =============================================================================
module activation_execution #(
    parameter int DATA_WIDTH   = 8,
    parameter int TILE_ELEMS   = 32,
    parameter int LEN_WIDTH    = 10,
    parameter int BUF_ID_WIDTH = 5
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start_i,
    input  logic [1:0]                         mode_i,
    input  logic [DATA_WIDTH-1:0]              clamp_max_i,
    input  logic [2:0]                         leak_shift_i,
    input  logic [BUF_ID_WIDTH-1:0]            x_buffer_id_i,
    input  logic [BUF_ID_WIDTH-1:0]            dest_buffer_id_i,
    input  logic [LEN_WIDTH-1:0]               length_i,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               vec_read_enable_o,
    output logic [BUF_ID_WIDTH-1:0]            vec_read_buffer_id_o,
    input  logic [TILE_ELEMS*DATA_WIDTH-1:0]   vec_read_tile_i,
    input  logic                               vec_read_valid_i,
    output logic                               vec_write_enable_o,
    output logic [BUF_ID_WIDTH-1:0]            vec_write_buffer_id_o,
    output logic [TILE_ELEMS*DATA_WIDTH-1:0]   vec_write_tile_o,
    output logic [LEN_WIDTH:0]                 zero_count_o
);

    localparam int CNT_W = LEN_WIDTH + 1;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_TILE = 2'd1;
    localparam logic [1:0] S_COMPLETE  = 2'd2;

    localparam logic [1:0] M_RELU  = 2'd1;
    localparam logic [1:0] M_CLAMP = 2'd2;
    localparam logic [1:0] M_LEAKY = 2'd3;

    logic [1:0]                       state_q, state_d;
    logic [1:0]                       mode_q, mode_d;
    logic signed [DATA_WIDTH-1:0]     clamp_q, clamp_d;
    logic [2:0]                       shift_q, shift_d;
    logic [LEN_WIDTH-1:0]             len_q, len_d;
    logic [BUF_ID_WIDTH-1:0]          xid_q, xid_d, did_q, did_d;
    logic [CNT_W-1:0]                 tiles_total_q, tiles_total_d;
    logic [CNT_W-1:0]                 tile_cnt_q, tile_cnt_d;
    logic [CNT_W-1:0]                 offset_q, offset_d;
    logic                             rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic                             busy_q, busy_d, done_q, done_d;
    logic [TILE_ELEMS*DATA_WIDTH-1:0] wr_tile_q, wr_tile_d;

    logic [TILE_ELEMS*DATA_WIDTH-1:0] w_act_tile;
    logic [TILE_ELEMS-1:0]            w_lane_valid;
    logic [CNT_W-1:0]                 w_tiles_needed;
    logic                             w_accept, w_capture, w_last_tile;

    function automatic logic signed [DATA_WIDTH-1:0] activate(
        input logic [1:0]                   m,
        input logic signed [DATA_WIDTH-1:0] x,
        input logic signed [DATA_WIDTH-1:0] cmax,
        input logic [2:0]                   sh
    );
        logic signed [DATA_WIDTH-1:0] y;
        y = x;
        case (m)
            M_RELU:  if (x[DATA_WIDTH-1]) y = '0;
            M_CLAMP: begin
                if (cmax[DATA_WIDTH-1] || x[DATA_WIDTH-1]) y = '0;
                else if (x > cmax)                         y = cmax;
            end
            M_LEAKY: if (x[DATA_WIDTH-1]) y = x >>> sh;
            default: y = x;
        endcase
        return y;
    endfunction

    assign w_tiles_needed = ({1'b0, length_i} + CNT_W'(TILE_ELEMS - 1)) / CNT_W'(TILE_ELEMS);
    assign w_accept       = (state_q == S_IDLE) && start_i;
    assign w_capture      = (state_q == S_WAIT_TILE) && vec_read_valid_i;
    assign w_last_tile    = (tile_cnt_q + CNT_W'(1)) == tiles_total_q;

    // Lanes past the vector length are forced to zero in the written tile.
    always_comb begin
        w_act_tile   = '0;
        w_lane_valid = '0;
        for (int i = 0; i < TILE_ELEMS; i++) begin
            w_lane_valid[i] = (offset_q + CNT_W'(i)) < {1'b0, len_q};
            if (w_lane_valid[i]) begin
                w_act_tile[i*DATA_WIDTH +: DATA_WIDTH] =
                    activate(mode_q, vec_read_tile_i[i*DATA_WIDTH +: DATA_WIDTH], clamp_q, shift_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start_i) state_d = (length_i == '0) ? S_COMPLETE : S_WAIT_TILE;
            S_WAIT_TILE: if (vec_read_valid_i && w_last_tile) state_d = S_COMPLETE;
            S_COMPLETE:  state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // busy stays high through the done cycle and drops on the edge after it.
    always_comb begin
        mode_d        = mode_q;
        clamp_d       = clamp_q;
        shift_d       = shift_q;
        len_d         = len_q;
        xid_d         = xid_q;
        did_d         = did_q;
        tiles_total_d = tiles_total_q;
        tile_cnt_d    = tile_cnt_q;
        offset_d      = offset_q;
        wr_tile_d     = wr_tile_q;
        rd_en_d       = 1'b0;
        wr_en_d       = 1'b0;
        done_d        = (state_q == S_COMPLETE);
        busy_d        = busy_q & ~done_q;
        if (w_accept) begin
            mode_d        = mode_i;
            clamp_d       = clamp_max_i;
            shift_d       = leak_shift_i;
            len_d         = length_i;
            xid_d         = x_buffer_id_i;
            did_d         = dest_buffer_id_i;
            tiles_total_d = w_tiles_needed;
            tile_cnt_d    = '0;
            offset_d      = '0;
            busy_d        = 1'b1;
            rd_en_d       = (length_i != '0);
        end
        if (w_capture) begin
            wr_tile_d  = w_act_tile;
            wr_en_d    = 1'b1;
            tile_cnt_d = tile_cnt_q + CNT_W'(1);
            offset_d   = offset_q + CNT_W'(TILE_ELEMS);
            rd_en_d    = ~w_last_tile;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q        <= '0;
            clamp_q       <= '0;
            shift_q       <= '0;
            len_q         <= '0;
            xid_q         <= '0;
            did_q         <= '0;
            tiles_total_q <= '0;
            tile_cnt_q    <= '0;
            offset_q      <= '0;
            wr_tile_q     <= '0;
            rd_en_q       <= 1'b0;
            wr_en_q       <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            clamp_q       <= clamp_d;
            shift_q       <= shift_d;
            len_q         <= len_d;
            xid_q         <= xid_d;
            did_q         <= did_d;
            tiles_total_q <= tiles_total_d;
            tile_cnt_q    <= tile_cnt_d;
            offset_q      <= offset_d;
            wr_tile_q     <= wr_tile_d;
            rd_en_q       <= rd_en_d;
            wr_en_q       <= wr_en_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
        end
    end

    assign busy_o                = busy_q;
    assign done_o                = done_q;
    assign vec_read_enable_o     = rd_en_q;
    assign vec_read_buffer_id_o  = xid_q;
    assign vec_write_enable_o    = wr_en_q;
    assign vec_write_buffer_id_o = did_q;
    assign vec_write_tile_o      = wr_tile_q;

`ifdef ACT_ZERO_COUNT_EN
    logic [CNT_W-1:0] zc_q, zc_d, w_zero_lanes;

    always_comb begin
        w_zero_lanes = '0;
        for (int i = 0; i < TILE_ELEMS; i++) begin
            w_zero_lanes = w_zero_lanes +
                CNT_W'(w_lane_valid[i] && (w_act_tile[i*DATA_WIDTH +: DATA_WIDTH] == '0));
        end
        zc_d = zc_q;
        if (w_accept)       zc_d = '0;
        else if (w_capture) zc_d = zc_q + w_zero_lanes;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) zc_q <= '0;
        else     zc_q <= zc_d;
    end

    assign zero_count_o = zc_q;
`else
    assign zero_count_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_activation_execution.sv
`default_nettype none
// =============================================================================
// Module   : tb_activation_execution
// Brief    : Directed self-checking bench with a latency-programmable tile memory.
// Revision : 1.0 - initial release
// =============================================================================
module tb_activation_execution;

    localparam int DW = 8;
    localparam int TE = 32;
    localparam int LW = 10;
    localparam int BW = 5;
    localparam int TW = TE * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic [DW-1:0] clamp_max;
    logic [2:0]    leak_shift;
    logic [BW-1:0] xid, did;
    logic [LW-1:0] length;
    logic          busy, done, rd_en, wr_en;
    logic [BW-1:0] rd_id, wr_id;
    logic [TW-1:0] rd_tile, wr_tile;
    logic          rd_valid;
    logic [LW:0]   zero_count;

    int n_vec = 0;
    int n_err = 0;

    // Memory/monitor state (written only by the memory process)
    int nidx = 0, due = -1, served = 0;
    int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, consec = 0;
    logic prev_rd = 1'b0, prev_wr = 1'b0;
    logic [TW-1:0] wr_log [8];
    logic [BW-1:0] rid_log [8];
    logic [BW-1:0] wid_log [8];
    // Memory configuration (written only by the main process)
    int tile_base = 0, lat = 1, stray_at = -1;
    logic [TW-1:0] tiles [4];

    always #5 clk = ~clk;

    activation_execution dut (
        .clk                   (clk),
        .rst                   (rst),
        .start_i               (start),
        .mode_i                (mode),
        .clamp_max_i           (clamp_max),
        .leak_shift_i          (leak_shift),
        .x_buffer_id_i         (xid),
        .dest_buffer_id_i      (did),
        .length_i              (length),
        .busy_o                (busy),
        .done_o                (done),
        .vec_read_enable_o     (rd_en),
        .vec_read_buffer_id_o  (rd_id),
        .vec_read_tile_i       (rd_tile),
        .vec_read_valid_i      (rd_valid),
        .vec_write_enable_o    (wr_en),
        .vec_write_buffer_id_o (wr_id),
        .vec_write_tile_o      (wr_tile),
        .zero_count_o          (zero_count)
    );

    // Tile memory: answers each read request lat cycles later; also logs traffic.
    initial begin
        rd_valid = 1'b0;
        rd_tile  = '0;
        forever begin
            @(negedge clk);
            nidx++;
            rd_valid = 1'b0;
            if (rst) begin
                due = -1;
            end else begin
                if (nidx == due) begin
                    rd_valid = 1'b1;
                    rd_tile  = tiles[(served - tile_base) % 4];
                    served++;
                    due = -1;
                end else if (nidx == stray_at) begin
                    rd_valid = 1'b1;
                    rd_tile  = {TE{8'h55}};
                end
                if (rd_en) due = nidx + lat;
            end
            if (rd_en) begin rid_log[rd_cnt % 8] = rd_id; rd_cnt++; end
            if (wr_en) begin wr_log[wr_cnt % 8] = wr_tile; wid_log[wr_cnt % 8] = wr_id; wr_cnt++; end
            if (done) done_cnt++;
            if ((rd_en && prev_rd) || (wr_en && prev_wr)) consec++;
            prev_rd = rd_en;
            prev_wr = wr_en;
        end
    end

    task automatic kick(input logic [1:0] m, input logic [DW-1:0] cm, input logic [2:0] sh,
                        input logic [BW-1:0] xi, input logic [BW-1:0] di, input logic [LW-1:0] len);
        @(negedge clk); #1;
        mode = m; clamp_max = cm; leak_shift = sh; xid = xi; did = di; length = len;
        tile_base = served;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int latc, output int busyc);
        bit seen;
        seen = 1'b0; latc = -1; busyc = 0;
        for (int k = 1; k <= 200 && !seen; k++) begin
            @(negedge clk); #1;
            if (busy) busyc++;
            if (done) begin seen = 1'b1; latc = k; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode = '0; clamp_max = '0; leak_shift = '0;
        xid = '0; did = '0; length = '0;
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if ({busy, done, rd_en, wr_en} !== 4'b0000) begin
            n_err++; $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, rd_en, wr_en});
        end
        n_vec++;
        if ({rd_id, wr_id, wr_tile, zero_count} !== '0) begin
            n_err++; $display("FAIL reset_data: got rd_id=%0d wr_id=%0d zc=%0d expected all 0", rd_id, wr_id, zero_count);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_relu();
        int l, b, r0, w0, c0, zc_exp;
        logic [TW-1:0] e0;
        for (int i = 0; i < TE; i++) begin
            tiles[0][i*DW +: DW] = DW'(i - 16);
            tiles[1][i*DW +: DW] = 8'hFD;
            e0[i*DW +: DW]       = (i <= 16) ? 8'd0 : DW'(i - 16);
        end
`ifdef ACT_ZERO_COUNT_EN
        zc_exp = 25;
`else
        zc_exp = 0;
`endif
        lat = 1;
        r0 = rd_cnt; w0 = wr_cnt; c0 = consec;
        kick(2'd1, 8'd0, 3'd0, 5'd3, 5'd9, 10'd40);
        wait_done(l, b);
        n_vec++; if (l != 6) begin n_err++; $display("FAIL relu_latency: got %0d expected 6", l); end
        n_vec++; if (rd_cnt - r0 != 2) begin n_err++; $display("FAIL relu_reads: got %0d expected 2", rd_cnt - r0); end
        n_vec++; if (wr_cnt - w0 != 2) begin n_err++; $display("FAIL relu_writes: got %0d expected 2", wr_cnt - w0); end
        n_vec++; if (wr_log[w0 % 8] !== e0) begin n_err++; $display("FAIL relu_tile0: got %h expected %h", wr_log[w0 % 8], e0); end
        n_vec++; if (wr_log[(w0 + 1) % 8] !== '0) begin n_err++; $display("FAIL relu_tile1: got %h expected 0", wr_log[(w0 + 1) % 8]); end
        n_vec++; if (int'(zero_count) != zc_exp) begin n_err++; $display("FAIL relu_zero_count: got %0d expected %0d", zero_count, zc_exp); end
        n_vec++; if (consec != c0) begin n_err++; $display("FAIL relu_single_strobe: got %0d expected 0", consec - c0); end
        @(negedge clk); #1;
        n_vec++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL relu_post_done: got %b expected 00", {busy, done}); end
    endtask

    task automatic test_clamp();
        int l, b, w0, zc_exp;
        int vin[5];
        logic [TW-1:0] e;
        vin = '{-5, 3, 6, 7, 127};
        tiles[0] = {TE{8'd99}};
        for (int i = 0; i < 5; i++) tiles[0][i*DW +: DW] = DW'(vin[i]);
        e = '0;
        e[1*DW +: DW] = 8'd3; e[2*DW +: DW] = 8'd6; e[3*DW +: DW] = 8'd6; e[4*DW +: DW] = 8'd6;
        lat = 1;
        w0 = wr_cnt;
        kick(2'd2, 8'd6, 3'd0, 5'd1, 5'd2, 10'd5);
        wait_done(l, b);
        n_vec++; if (l != 4) begin n_err++; $display("FAIL clamp_latency: got %0d expected 4", l); end
        n_vec++; if (wr_log[w0 % 8] !== e) begin n_err++; $display("FAIL clamp_pos: got %h expected %h", wr_log[w0 % 8], e); end
`ifdef ACT_ZERO_COUNT_EN
        zc_exp = 1;
`else
        zc_exp = 0;
`endif
        n_vec++; if (int'(zero_count) != zc_exp) begin n_err++; $display("FAIL clamp_zero_count: got %0d expected %0d", zero_count, zc_exp); end
        w0 = wr_cnt;
        kick(2'd2, 8'hFF, 3'd0, 5'd1, 5'd2, 10'd5);
        wait_done(l, b);
        n_vec++; if (wr_log[w0 % 8] !== '0) begin n_err++; $display("FAIL clamp_neg_max: got %h expected 0", wr_log[w0 % 8]); end
    endtask

    task automatic test_leaky_pass();
        int l, b, w0;
        logic [TW-1:0] e, ep;
        tiles[0] = {TE{8'd77}};
        tiles[0][0 +: 32] = {8'd5, 8'h80, 8'hFF, 8'hF9};
        e = '0;  e[0 +: 32]  = {8'd5, 8'hE0, 8'hFF, 8'hFE};
        ep = '0; ep[0 +: 32] = {8'd5, 8'h80, 8'hFF, 8'hF9};
        lat = 1;
        w0 = wr_cnt;
        kick(2'd3, 8'd0, 3'd2, 5'd4, 5'd5, 10'd4);
        wait_done(l, b);
        n_vec++; if (wr_log[w0 % 8] !== e) begin n_err++; $display("FAIL leaky_shift2: got %h expected %h", wr_log[w0 % 8], e); end
        w0 = wr_cnt;
        kick(2'd0, 8'd0, 3'd2, 5'd4, 5'd5, 10'd4);
        wait_done(l, b);
        n_vec++; if (wr_log[w0 % 8] !== ep) begin n_err++; $display("FAIL pass_through: got %h expected %h", wr_log[w0 % 8], ep); end
    endtask

    task automatic test_zero_length();
        int l, b, r0, w0;
        r0 = rd_cnt; w0 = wr_cnt;
        kick(2'd1, 8'd0, 3'd0, 5'd6, 5'd7, 10'd0);
        wait_done(l, b);
        repeat (3) @(negedge clk);
        n_vec++; if (l != 2) begin n_err++; $display("FAIL zero_len_latency: got %0d expected 2", l); end
        n_vec++; if (b != 2) begin n_err++; $display("FAIL zero_len_busy: got %0d cycles expected 2", b); end
        n_vec++; if ((rd_cnt - r0) + (wr_cnt - w0) != 0) begin n_err++; $display("FAIL zero_len_traffic: got %0d expected 0", (rd_cnt - r0) + (wr_cnt - w0)); end
    endtask

    task automatic test_ignore();
        int l, r0, w0;
        logic [TW-1:0] e0, e1;
        for (int i = 0; i < TE; i++) begin
            tiles[0][i*DW +: DW] = DW'(i - 16);
            tiles[1][i*DW +: DW] = DW'(i * 4 - 60);
            e0[i*DW +: DW] = (i <= 16) ? 8'd0 : DW'(i - 16);
            e1[i*DW +: DW] = (i < 15) ? 8'd0 : DW'(i * 4 - 60);
        end
        lat = 4;
        r0 = rd_cnt; w0 = wr_cnt;
        kick(2'd1, 8'd0, 3'd0, 5'd7, 5'd19, 10'd64);
        l = -1;
        for (int k = 1; k <= 200 && l < 0; k++) begin
            @(negedge clk); #1;
            if (k == 3) begin
                start = 1'b1; mode = 2'd0; xid = 5'd1; did = 5'd2; length = 10'd5;
            end
            if (k == 4)  start = 1'b0;
            if (k == 10) stray_at = nidx + 1;
            if (done) l = k;
        end
        repeat (4) @(negedge clk);
        stray_at = -1;
        n_vec++; if (l != 12) begin n_err++; $display("FAIL ignore_latency: got %0d expected 12", l); end
        n_vec++; if (wr_cnt - w0 != 2) begin n_err++; $display("FAIL ignore_writes: got %0d expected 2", wr_cnt - w0); end
        n_vec++; if (rd_cnt - r0 != 2) begin n_err++; $display("FAIL ignore_reads: got %0d expected 2", rd_cnt - r0); end
        n_vec++;
        if ({rid_log[r0 % 8], rid_log[(r0 + 1) % 8]} !== {5'd7, 5'd7}) begin
            n_err++; $display("FAIL ignore_read_ids: got %0d,%0d expected 7,7", rid_log[r0 % 8], rid_log[(r0 + 1) % 8]);
        end
        n_vec++;
        if ({wid_log[w0 % 8], wid_log[(w0 + 1) % 8]} !== {5'd19, 5'd19}) begin
            n_err++; $display("FAIL ignore_write_ids: got %0d,%0d expected 19,19", wid_log[w0 % 8], wid_log[(w0 + 1) % 8]);
        end
        n_vec++; if (wr_log[w0 % 8] !== e0) begin n_err++; $display("FAIL ignore_tile0: got %h expected %h", wr_log[w0 % 8], e0); end
        n_vec++; if (wr_log[(w0 + 1) % 8] !== e1) begin n_err++; $display("FAIL ignore_tile1: got %h expected %h", wr_log[(w0 + 1) % 8], e1); end
    endtask

    task automatic test_reset_midrun();
        int l, b, r0, w0, d0;
        logic [TW-1:0] e;
        for (int t = 0; t < 3; t++)
            for (int i = 0; i < TE; i++) tiles[t][i*DW +: DW] = DW'(i - 8);
        lat = 2;
        kick(2'd1, 8'd0, 3'd0, 5'd11, 5'd12, 10'd96);
        repeat (5) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_vec++; if ({busy, done, rd_en, wr_en} !== 4'b0000) begin n_err++; $display("FAIL midrst_ctrl: got %b expected 0000", {busy, done, rd_en, wr_en}); end
        n_vec++; if ({rd_id, wr_id} !== '0) begin n_err++; $display("FAIL midrst_ids: got %0d,%0d expected 0,0", rd_id, wr_id); end
        n_vec++; if ({wr_tile, zero_count} !== '0) begin n_err++; $display("FAIL midrst_data: got tile=%h zc=%0d expected 0", wr_tile, zero_count); end
        r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_vec++; if ((rd_cnt - r0) + (wr_cnt - w0) + (done_cnt - d0) != 0) begin n_err++; $display("FAIL midrst_quiet: got %0d events expected 0", (rd_cnt - r0) + (wr_cnt - w0) + (done_cnt - d0)); end
        tiles[0] = '0;
        tiles[0][0 +: 24] = {8'd3, 8'd2, 8'd1};
        e = '0; e[0 +: 24] = {8'd3, 8'd2, 8'd1};
        lat = 1;
        w0 = wr_cnt;
        kick(2'd0, 8'd0, 3'd0, 5'd13, 5'd14, 10'd3);
        wait_done(l, b);
        n_vec++; if (l != 4) begin n_err++; $display("FAIL restart_latency: got %0d expected 4", l); end
        n_vec++; if (wr_log[w0 % 8] !== e) begin n_err++; $display("FAIL restart_tile: got %h expected %h", wr_log[w0 % 8], e); end
    endtask

    initial begin
        test_reset();
        test_relu();
        test_clamp();
        test_leaky_pass();
        test_zero_length();
        test_ignore();
        test_reset_midrun();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
